// File: rtl/pattern_gen.sv
// Test-pattern generator for a dual-pixel LVDS panel: two independent pixel colours per clock,
// button-selected pattern mode that only switches on frame boundaries.
module pattern_gen #(
    parameter int H_ACTIVE        = 960,
    parameter int V_ACTIVE        = 1200,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    input  logic        i_btn,
    output logic [23:0] o_color,
    output logic [23:0] o_color_even,
    output logic [2:0]  o_mode,
    output logic [7:0]  o_frame
);

    localparam int CW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BAR_W = H_ACTIVE / 8;

    typedef enum logic [2:0] {
        MODE_BARS     = 3'd0,
        MODE_GRADIENT = 3'd1,
        MODE_CHECKER  = 3'd2,
        MODE_LINE     = 3'd3,
        MODE_GRID     = 3'd4
    } mode_e;

    logic          sync1_q, sync2_q;
    logic          dbLevel_q, dbLevel_d;
    logic [CW-1:0] dbCount_q, dbCount_d;
    logic          pending_q, pending_d;
    mode_e         mode_q, mode_d;
    logic [7:0]    frame_q, frame_d;
    logic [11:0]   prevY_q;
    logic [23:0]   color_q, color_d;
    logic [23:0]   colorEven_q, colorEven_d;

    logic          dbRise;
    logic          frameEdge;
    logic [2:0]    bar;
    logic          inRange;
    logic [11:0]   c0, c1;

    function automatic logic [23:0] barColor(input logic [2:0] b);
        case (b)
            3'd0:    barColor = 24'hFFFFFF;
            3'd1:    barColor = 24'hFFFF00;
            3'd2:    barColor = 24'h00FFFF;
            3'd3:    barColor = 24'h00FF00;
            3'd4:    barColor = 24'hFF00FF;
            3'd5:    barColor = 24'hFF0000;
            3'd6:    barColor = 24'h0000FF;
            default: barColor = 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] pixelColor(input logic [11:0] c, input logic [11:0] y,
                                               input mode_e mode, input logic [2:0] b,
                                               input logic [7:0] frame);
        pixelColor = 24'h000000;
        case (mode)
            MODE_BARS:     pixelColor = barColor(b);
            MODE_GRADIENT: pixelColor = {c[10:3], c[10:3], c[10:3]};
            MODE_CHECKER:  pixelColor = (c[5] ^ y[5]) ? 24'hFFFFFF : 24'h000000;
            MODE_LINE:     pixelColor = (c[10:3] == frame) ? 24'hFF0000 : 24'h000000;
            MODE_GRID: begin
                if (c == 12'd0 || c == 12'(2 * H_ACTIVE - 1) || y == 12'd0 ||
                    y == 12'(V_ACTIVE - 1) || c[5:0] == 6'd0 || y[5:0] == 6'd0)
                    pixelColor = 24'hFFFFFF;
            end
            default:       pixelColor = 24'h000000;
        endcase
    endfunction

    function automatic mode_e nextMode(input mode_e m);
        case (m)
            MODE_BARS:     nextMode = MODE_GRADIENT;
            MODE_GRADIENT: nextMode = MODE_CHECKER;
            MODE_CHECKER:  nextMode = MODE_LINE;
            MODE_LINE:     nextMode = MODE_GRID;
            default:       nextMode = MODE_BARS;
        endcase
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            dbLevel_q   <= 1'b0;
            dbCount_q   <= '0;
            pending_q   <= 1'b0;
            mode_q      <= MODE_BARS;
            frame_q     <= 8'd0;
            prevY_q     <= 12'd0;
            color_q     <= 24'h000000;
            colorEven_q <= 24'h000000;
        end else begin
            sync1_q     <= i_btn;
            sync2_q     <= sync1_q;
            dbLevel_q   <= dbLevel_d;
            dbCount_q   <= dbCount_d;
            pending_q   <= pending_d;
            mode_q      <= mode_d;
            frame_q     <= frame_d;
            prevY_q     <= i_y;
            color_q     <= color_d;
            colorEven_q <= colorEven_d;
        end
    end

    // Debounced level flips on the Nth consecutive clock of disagreement; agreement clears the count.
    always_comb begin
        dbLevel_d = dbLevel_q;
        dbCount_d = '0;
        if (sync2_q != dbLevel_q) begin
            if (dbCount_q == CW'(DEBOUNCE_CYCLES - 1))
                dbLevel_d = sync2_q;
            else
                dbCount_d = dbCount_q + 1'b1;
        end
        dbRise = ~dbLevel_q & dbLevel_d;
    end

    // A rise landing on the boundary clock is folded into pending before the advance decision.
    always_comb begin
        frameEdge = (prevY_q == 12'(V_ACTIVE - 1)) && (i_y == 12'd0);
        pending_d = pending_q | dbRise;
        mode_d    = mode_q;
        frame_d   = frame_q;
        if (frameEdge) begin
            frame_d = frame_q + 8'd1;
            if (pending_d) begin
                mode_d    = nextMode(mode_q);
                pending_d = 1'b0;
            end
        end
    end

    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (i_x >= 12'(k * BAR_W))
                bar = 3'(k);
        end
        inRange     = (i_x < 12'(H_ACTIVE)) && (i_y < 12'(V_ACTIVE));
        c0          = {i_x[10:0], 1'b0};
        c1          = {i_x[10:0], 1'b1};
        color_d     = 24'h000000;
        colorEven_d = 24'h000000;
        if (inRange) begin
            color_d     = pixelColor(c0, i_y, mode_q, bar, frame_q);
            colorEven_d = pixelColor(c1, i_y, mode_q, bar, frame_q);
        end
    end

    assign o_color      = color_q;
    assign o_color_even = colorEven_q;
    assign o_mode       = mode_q;
    assign o_frame      = frame_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: pattern colours, debounced mode stepping,
// frame counting with wrap, and reset discarding pending presses.
module tb_pattern_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] x, y;
    logic        btn;
    logic [23:0] color, colorEven;
    logic [2:0]  mode;
    logic [7:0]  frame;

    int assertionCount = 0;
    int failureCount   = 0;

    pattern_gen #(
        .H_ACTIVE(960),
        .V_ACTIVE(1200),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_x         (x),
        .i_y         (y),
        .i_btn       (btn),
        .o_color     (color),
        .o_color_even(colorEven),
        .o_mode      (mode),
        .o_frame     (frame)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [23:0] observed, input logic [23:0] expected);
        assertionCount++;
        if (observed !== expected) begin
            failureCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one clock worth of inputs; outputs are then sampled 1ns after the edge.
    task automatic applyStimulus(input logic [11:0] xv, input logic [11:0] yv, input logic b);
        x   = xv;
        y   = yv;
        btn = b;
        @(posedge clk);
        #1;
    endtask

    task automatic holdButton(input logic b, input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(12'd0, 12'd10, b);
    endtask

    task automatic pressButton();
        holdButton(1'b1, 24);
        holdButton(1'b0, 24);
    endtask

    task automatic frameBoundary();
        applyStimulus(12'd0, 12'd1199, 1'b0);
        applyStimulus(12'd0, 12'd0, 1'b0);
    endtask

    task automatic checkState(input string tag, input logic [2:0] m, input logic [7:0] f);
        checkOutput({tag, " mode"}, {21'd0, mode}, {21'd0, m});
        checkOutput({tag, " frame"}, {16'd0, frame}, {16'd0, f});
    endtask

    task automatic checkPixel(input string tag, input logic [11:0] xv, input logic [11:0] yv,
                              input logic [23:0] expC0, input logic [23:0] expC1);
        applyStimulus(xv, yv, 1'b0);
        checkOutput({tag, " c0"}, color, expC0);
        checkOutput({tag, " c1"}, colorEven, expC1);
    endtask

    initial begin
        logic [7:0]  expFrame;
        logic [11:0] lineX;
        logic [23:0] lineExp;

        $display("[TB] start");
        reset = 1'b1;
        applyStimulus(12'd0, 12'd10, 1'b0);
        applyStimulus(12'd0, 12'd10, 1'b0);
        checkOutput("reset color", color, 24'h000000);
        checkOutput("reset color_even", colorEven, 24'h000000);
        checkState("reset", 3'd0, 8'd0);
        reset = 1'b0;

        // Mode 0 colour bars, 120 pixel-pairs per bar
        checkPixel("bars x0", 12'd0, 12'd10, 24'hFFFFFF, 24'hFFFFFF);
        checkPixel("bars x959", 12'd959, 12'd10, 24'h000000, 24'h000000);
        checkPixel("bars x130", 12'd130, 12'd10, 24'hFFFF00, 24'hFFFF00);
        checkPixel("bars x500", 12'd500, 12'd10, 24'hFF00FF, 24'hFF00FF);
        checkPixel("bars x239", 12'd239, 12'd10, 24'hFFFF00, 24'hFFFF00);
        checkPixel("bars x240", 12'd240, 12'd10, 24'h00FFFF, 24'h00FFFF);
        checkPixel("bars x960", 12'd960, 12'd10, 24'h000000, 24'h000000);
        checkPixel("bars y1200", 12'd0, 12'd1200, 24'h000000, 24'h000000);

        // Short glitch must not be accepted
        holdButton(1'b1, 10);
        holdButton(1'b0, 24);
        frameBoundary();
        checkState("glitch", 3'd0, 8'd1);

        holdButton(1'b1, 40);
        holdButton(1'b0, 30);
        checkState("pending no change", 3'd0, 8'd1);
        frameBoundary();
        checkState("press1", 3'd1, 8'd2);

        checkPixel("grad x100", 12'd100, 12'd10, 24'h191919, 24'h191919);
        checkPixel("grad x960", 12'd960, 12'd10, 24'h000000, 24'h000000);
        checkPixel("grad x959", 12'd959, 12'd10, 24'hEFEFEF, 24'hEFEFEF);
        checkPixel("grad x0", 12'd0, 12'd10, 24'h000000, 24'h000000);

        // Two presses within one frame yield one step
        pressButton();
        pressButton();
        frameBoundary();
        checkState("double press", 3'd2, 8'd3);

        checkPixel("chk x16 y10", 12'd16, 12'd10, 24'hFFFFFF, 24'hFFFFFF);
        checkPixel("chk x0 y32", 12'd0, 12'd32, 24'hFFFFFF, 24'hFFFFFF);
        checkPixel("chk x16 y32", 12'd16, 12'd32, 24'h000000, 24'h000000);
        checkPixel("chk x0 y10", 12'd0, 12'd10, 24'h000000, 24'h000000);

        pressButton();
        frameBoundary();
        checkState("to line", 3'd3, 8'd4);
        checkPixel("line x16", 12'd16, 12'd10, 24'hFF0000, 24'hFF0000);
        checkPixel("line x20", 12'd20, 12'd10, 24'h000000, 24'h000000);

        pressButton();
        frameBoundary();
        checkState("to grid", 3'd4, 8'd5);
        checkPixel("grid x0", 12'd0, 12'd10, 24'hFFFFFF, 24'h000000);
        checkPixel("grid x32", 12'd32, 12'd10, 24'hFFFFFF, 24'h000000);
        checkPixel("grid x959", 12'd959, 12'd10, 24'h000000, 24'hFFFFFF);
        checkPixel("grid y1199", 12'd5, 12'd1199, 24'hFFFFFF, 24'hFFFFFF);
        checkPixel("grid y64", 12'd5, 12'd64, 24'hFFFFFF, 24'hFFFFFF);
        checkPixel("grid y65", 12'd5, 12'd65, 24'h000000, 24'h000000);

        pressButton();
        pressButton();
        frameBoundary();
        checkState("wrap mode", 3'd0, 8'd6);

        frameBoundary();
        checkState("plain boundary", 3'd0, 8'd7);

        // Reset with a press pending and the last line already seen
        pressButton();
        applyStimulus(12'd0, 12'd1199, 1'b0);
        reset = 1'b1;
        applyStimulus(12'd0, 12'd1199, 1'b0);
        checkOutput("midreset color", color, 24'h000000);
        checkOutput("midreset color_even", colorEven, 24'h000000);
        checkState("midreset", 3'd0, 8'd0);
        reset = 1'b0;
        applyStimulus(12'd0, 12'd0, 1'b0);
        checkState("no boundary after reset", 3'd0, 8'd0);
        frameBoundary();
        checkState("post reset boundary", 3'd0, 8'd1);

        for (int i = 0; i < 3; i++) begin
            pressButton();
            frameBoundary();
        end
        checkState("line again", 3'd3, 8'd4);

        // 256 frames: counter wraps, line follows the frame number
        for (int i = 1; i <= 256; i++) begin
            frameBoundary();
            expFrame = 8'(4 + i);
            checkOutput("frame count", {16'd0, frame}, {16'd0, expFrame});
            if (expFrame < 8'd240) begin
                lineX   = {2'd0, expFrame, 2'd0};
                lineExp = 24'hFF0000;
            end else begin
                lineX   = 12'd100;
                lineExp = 24'h000000;
            end
            checkPixel("line track", lineX, 12'd10, lineExp, lineExp);
        end
        checkState("after 256", 3'd3, 8'd4);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertionCount, failureCount);
        $finish;
    end

endmodule
